aes_round_seq: RTL and testbench
================================

// Module: aes_round_seq
// PURPOSE
//  Round sequencer and initiator for the low-area AES-128 core. Holds the 128-bit state and
//  applies AddRoundKey and (Inv)ShiftRows internally. Drives the external SubBytes and
//  MixColumns units over their start/ready handshake. Fetches round keys from the key-schedule block.
//  Byte i of the state occupies bits [127-8i -: 8]; i = 4*col + row. Column 0 is bits [127:96].
// PARAMETERS
//  TIMEOUT  64  max cycles waiting on any ready/ack before abort; 0 disables
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  start_i      in   1    start one block; sampled in IDLE only
//  decrypt_i    in   1    0=encrypt, 1=decrypt; sampled with start_i
//  data_i       in   128  input block; sampled with start_i
//  ready_o      out  1    1-cycle pulse: data_o valid
//  data_o       out  128  result block; held until next completion
//  busy_o       out  1    high in every state except IDLE
//  err_o        out  1    1-cycle pulse on timeout abort
//  key_req_o    out  1    round-key request; level, high in KEY state
//  round_o      out  4    round-key index 0..10
//  key_ack_i    in   1    key_i valid this cycle
//  key_i        in   128  round key round_o
//  sub_start_o  out  1    SubBytes start pulse
//  sub_dec_o    out  1    latched decrypt flag (to SubBytes and MixColumns)
//  sub_data_o   out  128  SubBytes operand
//  sub_ready_i  in   1    SubBytes result valid
//  sub_data_i   in   128  SubBytes result
//  mix_start_o  out  1    MixColumns start pulse
//  mix_data_o   out  128  MixColumns operand (= state register)
//  mix_ready_i  in   1    MixColumns result valid
//  mix_data_i   in   128  MixColumns result
// BEHAVIOUR
//  Reset: all outputs 0, state register 0, round 0, FSM=IDLE. Reset mid-block aborts with no ready_o/err_o pulse.
//  States: IDLE, KEY, SUB_ST, SUB_WT, MIX_ST, MIX_WT.
//  IDLE: on start_i, state<=data_i and dec<=decrypt_i. round<=0 (enc) or 10 (dec). Go to KEY.
//    start_i outside IDLE is ignored.
//  KEY: key_req_o=1. On key_ack_i, state<=state^key_i and advance:
//    enc: round==10 -> finish; else round<=round+1, go to SUB_ST.
//    dec: round==0 -> finish; round==10 -> round<=9, go to SUB_ST; else go to MIX_ST.
//  finish: data_o<=state^key_i; ready_o=1 in the next cycle; go to IDLE.
//  SUB_ST: sub_start_o=1 for exactly this cycle, then go to SUB_WT. Any ready seen in this cycle is ignored.
//  sub_data_o = state (enc) or InvShiftRows(state) (dec). Combinational from the state register.
//  SUB_WT: on sub_ready_i:
//    enc: state<=ShiftRows(sub_data_i); round==10 -> KEY, else -> MIX_ST.
//    dec: state<=sub_data_i; go to KEY.
//  MIX_ST: mix_start_o=1 for exactly this cycle, then go to MIX_WT.
//  MIX_WT: on mix_ready_i, state<=mix_data_i. enc -> KEY; dec -> round<=round-1, go to SUB_ST.
//  The state register is stable from start to ready. Operands therefore stay constant, as the
//  MixColumns unit re-reads its input on each of its 4 column cycles.
//  ShiftRows: out[row,col]=in[row,(col+row)%4]. InvShiftRows: out[row,col]=in[row,(col-row)%4].
//  Latency: zero-wait key_ack, sub ready Ls cycles after its start cycle, mix ready Lm cycles after its start cycle.
//    ready_o is high at cycle T+31+10*Ls+9*Lm, where T is the start_i cycle.
//    Same for both directions: 11 KEY, 10 SUB, 9 MIX passes.
//  Timeout: counter clears on each state entry and counts in KEY, SUB_WT and MIX_WT.
//    At count==TIMEOUT: err_o pulses, FSM goes to IDLE, data_o unchanged, no ready_o.
//  Simultaneous ack and timeout in the same cycle: the ack wins.
// TESTING
//  1 FIPS-197 App.B, enc: data 3243f6a8885a308d313198a2e0370734, keys from 2b7e151628aed2a6abf7158809cf4f3c.
//    -> data_o=3925841d02dc09fbdc118597196a0b32, ready_o at T+107 (Ls=Lm=4).
//  2 App.C.1 dec: data 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102..0f -> data_o=00112233445566778899aabbccddeeff.
//  3 Random 0-7 cycle stalls on key_ack_i, sub_ready_i, mix_ready_i; start_i held high during busy.
//    -> same results; one ready_o per block; operands stable while waiting.
//  4 Hold mix_ready_i low, TIMEOUT=64 -> err_o pulse 64 cycles after MIX_WT entry; busy_o=0; data_o unchanged.
//  5 Reset asserted mid-round 5 -> all outputs 0 immediately; a new start_i then produces the correct App.B result.
//  6 Back-to-back: start_i in the cycle after ready_o -> accepted; second result correct.

Source files
------------

// File: rtl/aes_round_seq.sv
// AES-128 round sequencer: owns the block state, applies AddRoundKey/ShiftRows locally and
// drives the external SubBytes/MixColumns units and key-schedule fetch over start/ready handshakes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start_i
// S_KEY    | requesting round key r_round, AddRoundKey on ack
// S_SUB_ST | one-cycle SubBytes start
// S_SUB_WT | waiting for SubBytes result
// S_MIX_ST | one-cycle MixColumns start
// S_MIX_WT | waiting for MixColumns result
module aes_round_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         busy_o,
  output logic         err_o,
  output logic         key_req_o,
  output logic [3:0]   round_o,
  input  logic         key_ack_i,
  input  logic [127:0] key_i,
  output logic         sub_start_o,
  output logic         sub_dec_o,
  output logic [127:0] sub_data_o,
  input  logic         sub_ready_i,
  input  logic [127:0] sub_data_i,
  output logic         mix_start_o,
  output logic [127:0] mix_data_o,
  input  logic         mix_ready_i,
  input  logic [127:0] mix_data_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_SUB_ST, S_SUB_WT, S_MIX_ST, S_MIX_WT
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT > 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t       r_fsm;
  state_t       w_nxt;
  logic [127:0] r_state;
  logic [127:0] r_data;
  logic [3:0]   r_round;
  logic [15:0]  r_tmo;
  logic         r_dec;
  logic         r_ready;
  logic         r_err;
  logic         r_busy;
  logic         r_key_req;
  logic         r_sub_start;
  logic         r_mix_start;
  logic         w_tmo_hit;
  logic         w_finish;
  logic         w_abort;

  // out[row,col] = in[row,(col+row)%4]; inverse rotates the other way
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(inv ? (c - r + 4) % 4 : (c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);

  always_comb begin
    w_nxt    = r_fsm;
    w_finish = 1'b0;
    w_abort  = 1'b0;
    case (r_fsm)
      S_IDLE: if (start_i) w_nxt = S_KEY;
      S_KEY: begin
        if (key_ack_i) begin
          if (r_dec ? (r_round == 4'd0) : (r_round == 4'd10)) begin
            w_finish = 1'b1;
            w_nxt    = S_IDLE;
          end else if (!r_dec || r_round == 4'd10) begin
            w_nxt = S_SUB_ST;
          end else begin
            w_nxt = S_MIX_ST;
          end
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_nxt   = S_IDLE;
        end
      end
      S_SUB_ST: w_nxt = S_SUB_WT;
      S_SUB_WT: begin
        if (sub_ready_i) begin
          w_nxt = (!r_dec && r_round != 4'd10) ? S_MIX_ST : S_KEY;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_nxt   = S_IDLE;
        end
      end
      S_MIX_ST: w_nxt = S_MIX_WT;
      S_MIX_WT: begin
        if (mix_ready_i) begin
          w_nxt = r_dec ? S_SUB_ST : S_KEY;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_nxt   = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_data      <= '0;
      r_round     <= '0;
      r_tmo       <= '0;
      r_dec       <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_key_req   <= 1'b0;
      r_sub_start <= 1'b0;
      r_mix_start <= 1'b0;
    end else begin
      r_fsm       <= w_nxt;
      r_tmo       <= (w_nxt != r_fsm || r_fsm == S_IDLE) ? '0 : r_tmo + 16'd1;
      r_ready     <= w_finish;
      r_err       <= w_abort;
      r_busy      <= (w_nxt != S_IDLE);
      r_key_req   <= (w_nxt == S_KEY);
      r_sub_start <= (w_nxt == S_SUB_ST);
      r_mix_start <= (w_nxt == S_MIX_ST);
      case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            r_state <= data_i;
            r_dec   <= decrypt_i;
            r_round <= decrypt_i ? 4'd10 : 4'd0;
          end
        end
        S_KEY: begin
          if (key_ack_i) begin
            r_state <= r_state ^ key_i;
            if (w_finish)                r_data  <= r_state ^ key_i;
            else if (!r_dec)             r_round <= r_round + 4'd1;
            else if (r_round == 4'd10)   r_round <= 4'd9;
          end
        end
        S_SUB_WT: begin
          if (sub_ready_i) r_state <= r_dec ? sub_data_i : shift_rows(sub_data_i, 1'b0);
        end
        S_MIX_WT: begin
          if (mix_ready_i) begin
            r_state <= mix_data_i;
            if (r_dec) r_round <= r_round - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign data_o      = r_data;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign key_req_o   = r_key_req;
  assign round_o     = r_round;
  assign sub_start_o = r_sub_start;
  assign sub_dec_o   = r_dec;
  assign sub_data_o  = r_dec ? shift_rows(r_state, 1'b1) : r_state;
  assign mix_start_o = r_mix_start;
  assign mix_data_o  = r_state;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: emulates key schedule, SubBytes and MixColumns units and compares
// every block against a byte-level AES-128 reference model and FIPS-197 vectors.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         decrypt_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         ready_o;
  logic [127:0] data_o;
  logic         busy_o;
  logic         err_o;
  logic         key_req_o;
  logic [3:0]   round_o;
  logic         key_ack_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         sub_start_o;
  logic         sub_dec_o;
  logic [127:0] sub_data_o;
  logic         sub_ready_i = 1'b0;
  logic [127:0] sub_data_i = '0;
  logic         mix_start_o;
  logic [127:0] mix_data_o;
  logic         mix_ready_i = 1'b0;
  logic [127:0] mix_data_i = '0;

  always #5 clk = ~clk;

  aes_round_seq #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .decrypt_i(decrypt_i), .data_i(data_i),
    .ready_o(ready_o), .data_o(data_o), .busy_o(busy_o), .err_o(err_o),
    .key_req_o(key_req_o), .round_o(round_o), .key_ack_i(key_ack_i), .key_i(key_i),
    .sub_start_o(sub_start_o), .sub_dec_o(sub_dec_o), .sub_data_o(sub_data_o),
    .sub_ready_i(sub_ready_i), .sub_data_i(sub_data_i),
    .mix_start_o(mix_start_o), .mix_data_o(mix_data_o),
    .mix_ready_i(mix_ready_i), .mix_data_i(mix_data_i)
  );

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT     = 128'h00112233445566778899aabbccddeeff;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [11];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_ready = 0;
  int n_err = 0;
  int mix_start_cyc = 0;
  bit stall_en = 0;
  bit hold_start = 0;
  bit hold_mix = 0;
  int cfg_ls = 4;
  int cfg_lm = 4;

  bit           key_pend = 0, sub_pend = 0, mix_pend = 0;
  int           key_cnt = 0, sub_cnt = 0, mix_cnt = 0;
  logic [127:0] sub_op = '0, mix_op = '0;
  logic         sub_dc = 1'b0, mix_dc = 1'b0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_bytes_f(input logic [127:0] s, input logic inv);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  // row r rotates left by r columns (right by r when inverse)
  function automatic logic [127:0] shift_rows_f(input logic [127:0] s, input logic inv);
    logic [7:0]   m[4][4];
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = inv ? m[r][(c + 4 - r) % 4] : m[r][(c + r) % 4];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols_f(input logic [127:0] s, input logic inv);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      if (!inv)
        o[127-32*c -: 32] = {
          gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
          a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
          a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
          gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
      else
        o[127-32*c -: 32] = {
          gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
          gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
          gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
          gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] din, input logic dec);
    logic [127:0] s;
    if (!dec) begin
      s = din ^ rk[0];
      for (int r = 1; r < 10; r++)
        s = mix_cols_f(shift_rows_f(sub_bytes_f(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
      s = shift_rows_f(sub_bytes_f(s, 1'b0), 1'b0) ^ rk[10];
    end else begin
      s = din ^ rk[10];
      for (int r = 9; r > 0; r--)
        s = mix_cols_f(sub_bytes_f(shift_rows_f(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
      s = sub_bytes_f(shift_rows_f(s, 1'b1), 1'b1) ^ rk[0];
    end
    return s;
  endfunction

  // Environment: key schedule and SubBytes/MixColumns responders, one step per cycle
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      key_ack_i   = 1'b0;
      sub_ready_i = 1'b0;
      mix_ready_i = 1'b0;
      key_i       = rnd128();
      sub_data_i  = rnd128();
      mix_data_i  = rnd128();
      if (ready_o) n_ready++;
      if (err_o)   n_err++;
      if (!reset || !busy_o) begin
        key_pend = 0;
        sub_pend = 0;
        mix_pend = 0;
      end else begin
        if (key_req_o) begin
          if (!key_pend) begin
            key_pend = 1;
            key_cnt  = stall_en ? int'($urandom_range(0, 7)) : 0;
          end
          if (key_cnt == 0) begin
            key_ack_i = 1'b1;
            key_i     = rk[round_o];
            key_pend  = 0;
          end else begin
            key_cnt--;
          end
        end
        if (sub_pend) begin
          sub_cnt--;
          if (sub_cnt == 0) begin
            check("sub_operand_stable", sub_data_o, sub_op);
            sub_ready_i = 1'b1;
            sub_data_i  = sub_bytes_f(sub_op, sub_dc);
            sub_pend    = 0;
          end
        end
        if (sub_start_o) begin
          sub_pend = 1;
          sub_op   = sub_data_o;
          sub_dc   = sub_dec_o;
          sub_cnt  = stall_en ? int'($urandom_range(1, 8)) : cfg_ls;
          if (stall_en) sub_ready_i = 1'b1;
        end
        if (mix_pend && !hold_mix) begin
          mix_cnt--;
          if (mix_cnt == 0) begin
            check("mix_operand_stable", mix_data_o, mix_op);
            mix_ready_i = 1'b1;
            mix_data_i  = mix_cols_f(mix_op, mix_dc);
            mix_pend    = 0;
          end
        end
        if (mix_start_o) begin
          mix_pend      = 1;
          mix_op        = mix_data_o;
          mix_dc        = sub_dec_o;
          mix_cnt       = stall_en ? int'($urandom_range(1, 8)) : cfg_lm;
          mix_start_cyc = cyc;
          if (stall_en) mix_ready_i = 1'b1;
        end
      end
    end
  end

  task automatic run_block(input logic [127:0] din, input logic dec, input logic [127:0] exp,
                           input int exp_lat, input string tag);
    int t0, nr0, ne0;
    bit seen = 0;
    @(posedge clk); #2;
    start_i = 1'b1; decrypt_i = dec; data_i = din;
    t0 = cyc; nr0 = n_ready; ne0 = n_err;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #2;
      if (ready_o) begin
        seen = 1;
        break;
      end
      if (hold_start) begin
        start_i = 1'b1; decrypt_i = 1'($urandom_range(0, 1)); data_i = rnd128();
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check({tag, "_done"}, 128'(seen), 128'(1));
    if (seen) begin
      check({tag, "_data"}, data_o, exp);
      check({tag, "_busy"}, 128'(busy_o), 128'(0));
      if (exp_lat > 0) check({tag, "_latency"}, 128'(cyc - t0), 128'(exp_lat));
    end
    check({tag, "_ready_count"}, 128'(n_ready - nr0), 128'(1));
    check({tag, "_err_count"}, 128'(n_err - ne0), 128'(0));
  endtask

  task automatic timeout_test();
    logic [127:0] d_prev;
    int nr0;
    bit seen = 0;
    expand_key(FIPS_KEY);
    hold_mix = 1;
    d_prev = data_o;
    nr0 = n_ready;
    @(posedge clk); #2;
    start_i = 1'b1; decrypt_i = 1'b0; data_i = FIPS_PT;
    @(posedge clk); #2;
    start_i = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (err_o) begin
        seen = 1;
        break;
      end
      @(posedge clk); #2;
    end
    check("tmo_seen", 128'(seen), 128'(1));
    check("tmo_delay_from_mix_start", 128'(cyc - mix_start_cyc), 128'(65));
    check("tmo_busy", 128'(busy_o), 128'(0));
    check("tmo_data_held", data_o, d_prev);
    check("tmo_no_ready", 128'(n_ready - nr0), 128'(0));
    @(posedge clk); #2;
    check("tmo_err_pulse", 128'(err_o), 128'(0));
    hold_mix = 0;
  endtask

  task automatic reset_test();
    int nr0, ne0;
    bit seen = 0;
    expand_key(FIPS_KEY);
    @(posedge clk); #2;
    start_i = 1'b1; decrypt_i = 1'b0; data_i = FIPS_PT;
    @(posedge clk); #2;
    start_i = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (round_o == 4'd5) begin
        seen = 1;
        break;
      end
      @(posedge clk); #2;
    end
    check("rst_reached_round5", 128'(seen), 128'(1));
    repeat (3) @(posedge clk);
    #2;
    nr0 = n_ready; ne0 = n_err;
    reset = 1'b0;
    #1;
    check("rst_mid_data_o", data_o, '0);
    check("rst_mid_sub_data", sub_data_o, '0);
    check("rst_mid_mix_data", mix_data_o, '0);
    check("rst_mid_flags", 128'({ready_o, busy_o, err_o, key_req_o, sub_start_o, sub_dec_o,
                                 mix_start_o, round_o}), '0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    check("rst_no_pulses", 128'({n_ready - nr0, n_err - ne0}), '0);
    run_block(FIPS_PT, 1'b0, FIPS_CT, 107, "after_reset");
  endtask

  initial begin
    logic [127:0] pt;
    logic         dc;
    build_sbox();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_data_o", data_o, '0);
    check("reset_mix_data", mix_data_o, '0);
    check("reset_flags", 128'({ready_o, busy_o, err_o, key_req_o, sub_start_o, sub_dec_o,
                               mix_start_o, round_o}), '0);
    reset = 1'b1;

    expand_key(FIPS_KEY);
    run_block(FIPS_PT, 1'b0, FIPS_CT, 107, "fips_enc");
    expand_key(C1_KEY);
    run_block(C1_CT, 1'b1, C1_PT, 107, "c1_dec");

    for (int i = 0; i < 4; i++) begin
      cfg_ls = int'($urandom_range(1, 6));
      cfg_lm = int'($urandom_range(1, 6));
      expand_key(rnd128());
      pt = rnd128();
      dc = 1'($urandom_range(0, 1));
      run_block(pt, dc, aes_ref(pt, dc), 31 + 10 * cfg_ls + 9 * cfg_lm, "rand_lat");
    end
    cfg_ls = 4;
    cfg_lm = 4;

    stall_en = 1;
    hold_start = 1;
    for (int i = 0; i < 5; i++) begin
      expand_key(rnd128());
      pt = rnd128();
      dc = 1'($urandom_range(0, 1));
      run_block(pt, dc, aes_ref(pt, dc), 0, "stall");
    end
    stall_en = 0;
    hold_start = 0;

    expand_key(FIPS_KEY);
    run_block(FIPS_PT, 1'b0, FIPS_CT, 107, "b2b_first");
    run_block(FIPS_CT, 1'b1, FIPS_PT, 107, "b2b_second");

    timeout_test();
    reset_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
